// File: rtl/word_stream_rr_arbiter.sv
// Round-robin, packet-locked arbiter feeding one word stream from NUM_SRC sources.
// Build option WSA_SKID_REG_EN: registered two-entry skid buffer on the M_AXIS side.
module word_stream_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_W      = 2
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
    input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
    output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TLAST,
    output logic [SRC_W-1:0]              M_AXIS_TID,
    input  logic                          M_AXIS_TREADY,
    output logic                          GRANT_ACTIVE,
    output logic [SRC_W-1:0]              GRANT_IDX
);

    // Handshake: a beat moves on an interface in the cycle where its TVALID and
    // TREADY are both high at the rising edge; TVALID never waits on TREADY.

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state;
    logic [SRC_W-1:0]        grant_idx;
    logic [SRC_W-1:0]        last_grant;

    logic                    any_req;
    logic [SRC_W-1:0]        next_pick;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    in_ready_g;
    logic                    in_accept;

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        return SRC_W'(sum);
    endfunction

    // Walk downwards so the smallest offset from last_grant+1 wins.
    always_comb begin
        any_req   = 1'b0;
        next_pick = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (S_AXIS_TVALID[wrap_idx(last_grant, k)]) begin
                any_req   = 1'b1;
                next_pick = wrap_idx(last_grant, k);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                sel_data  = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = S_AXIS_TVALID[i];
                sel_last  = S_AXIS_TLAST[i];
            end
        end
    end

    assign in_accept = (state == LOCKED) && sel_valid && in_ready_g;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx <= next_pick;
                        state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_accept && sel_last) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign GRANT_ACTIVE = (state == LOCKED);
    assign GRANT_IDX    = grant_idx;

`ifdef WSA_SKID_REG_EN
    logic [NUM_SRC-1:0]    tready_q;
    logic [NUM_SRC-1:0]    tready_nxt;
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic [SRC_W-1:0]      out_tid;
    logic                  skid_valid;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [SRC_W-1:0]      skid_tid;
    logic                  pop;
    logic                  out_free;
    logic                  skid_valid_nxt;

    assign S_AXIS_TREADY  = tready_q;
    assign in_ready_g     = tready_q[grant_idx];
    assign pop            = out_valid && M_AXIS_TREADY;
    assign out_free       = !out_valid || pop;
    assign skid_valid_nxt = out_free ? (skid_valid && in_accept) : (skid_valid || in_accept);

    // Ready is offered for the next cycle only if the skid slot will be free,
    // so a beat taken under a stalled output always has somewhere to land.
    always_comb begin
        tready_nxt = '0;
        if (!skid_valid_nxt) begin
            if (state == IDLE && any_req) begin
                tready_nxt[next_pick] = 1'b1;
            end else if (state == LOCKED && !(in_accept && sel_last)) begin
                tready_nxt[grant_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tready_q   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_tid    <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            skid_tid   <= '0;
        end else begin
            tready_q <= tready_nxt;
            if (out_free) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_last  <= skid_last;
                    out_tid   <= skid_tid;
                end else begin
                    out_valid <= in_accept;
                    if (in_accept) begin
                        out_data <= sel_data;
                        out_last <= sel_last;
                        out_tid  <= grant_idx;
                    end
                end
            end
            if (skid_valid_nxt && in_accept) begin
                skid_data <= sel_data;
                skid_last <= sel_last;
                skid_tid  <= grant_idx;
            end
            skid_valid <= skid_valid_nxt;
        end
    end

    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = out_data;
    assign M_AXIS_TLAST  = out_last;
    assign M_AXIS_TID    = out_tid;
`else
    always_comb begin
        S_AXIS_TREADY = '0;
        if (state == LOCKED && M_AXIS_TREADY) S_AXIS_TREADY[grant_idx] = 1'b1;
    end

    assign in_ready_g    = M_AXIS_TREADY;
    assign M_AXIS_TVALID = (state == LOCKED) && sel_valid;
    assign M_AXIS_TLAST  = (state == LOCKED) && sel_last;
    assign M_AXIS_TDATA  = (state == LOCKED) ? sel_data : '0;
    assign M_AXIS_TID    = grant_idx;
`endif

endmodule
